// File: rtl/stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// stream_demux_1xn
//
// Registered 1-to-N stream demultiplexer with a valid/ready handshake.
// Each accepted input beat is routed to one of N_CH output channels chosen
// by in_sel and is presented one cycle later from a single holding register
// {data, sel}. Beats whose select is out of range (in_sel >= N_CH) are
// consumed, not stored, and counted in a saturating drop counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps valid/data/sel stable until accepted. A
// consumer on channel k sees a beat while out_valid[k]=1 and takes it on
// the edge where out_ready[k]=1. out_ready bits of channels that do not
// hold the beat are ignored.
//
// Optional feature (macro DEMUX_PKT_LOCK_EN): packet mode. The select of
// the first beat of a packet is latched and every following beat up to and
// including the one with in_last=1 goes to that channel. Without the macro
// in_last is ignored and there is no packet FSM.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   producer beat valid
//   in_ready   block can accept a beat this cycle (combinational)
//   in_data    beat data
//   in_sel     destination channel index
//   in_last    last beat of packet (packet mode only)
//   out_valid  one-hot (or zero) valid, bit k = channel k
//   out_ready  per-channel consumer ready
//   out_data   shared data bus, qualified by out_valid[k]
//   drop_cnt   saturating count of beats dropped for in_sel >= N_CH
//   dbg_state  {packet FSM busy, holding register full}
// -----------------------------------------------------------------------------
module stream_demux_1xn #(
  parameter int N_CH   = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        dbg_state
);

  // Holding register and drop counter
  logic              full_q, full_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              drain_ok;
  logic              accept;
  logic [SEL_W-1:0]  eff_sel;
  logic              sel_ok;
  logic              pkt_busy;

  // Decode the held select into a one-hot valid. Only registers feed this.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < N_CH; k++) begin
      out_valid[k] = full_q && (sel_q == SEL_W'(k));
    end
  end

  // Drain happens when the channel holding the beat is ready; masking with
  // out_valid makes every other channel's ready irrelevant.
  assign drain_ok = |(out_valid & out_ready);
  assign in_ready = !rst && (!full_q || drain_ok);
  assign accept   = in_valid && in_ready;

`ifdef DEMUX_PKT_LOCK_EN
  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_BUSY = 1'b1
  } pkt_state_e;

  pkt_state_e       pkt_q;
  logic [SEL_W-1:0] lock_sel_q;

  // Packet lock FSM: the first accepted beat of a packet latches its select,
  // later beats of the same packet reuse it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q      <= PKT_IDLE;
      lock_sel_q <= '0;
    end else if (accept) begin
      case (pkt_q)
        PKT_IDLE: begin
          lock_sel_q <= in_sel;
          if (!in_last) pkt_q <= PKT_BUSY;
        end
        PKT_BUSY: begin
          if (in_last) pkt_q <= PKT_IDLE;
        end
        default: pkt_q <= PKT_IDLE;
      endcase
    end
  end

  assign eff_sel  = (pkt_q == PKT_BUSY) ? lock_sel_q : in_sel;
  assign pkt_busy = (pkt_q == PKT_BUSY);
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign eff_sel        = in_sel;
  assign pkt_busy       = 1'b0;
`endif

  assign sel_ok = int'(eff_sel) < N_CH;

  // Next-state of the holding register. A valid accept always loads, since
  // accept while full implies the old beat drains in the same edge. An
  // invalid accept leaves the register to the drain rule alone.
  always_comb begin
    full_d = full_q;
    sel_d  = sel_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (accept && sel_ok) begin
      full_d = 1'b1;
      sel_d  = eff_sel;
      data_d = in_data;
    end else if (drain_ok) begin
      full_d = 1'b0;
    end
    if (accept && !sel_ok && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      sel_q  <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      sel_q  <= sel_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign drop_cnt  = cnt_q;
  assign dbg_state = {pkt_busy, full_q};

endmodule

// File: tb/tb_stream_demux_1xn.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1xn
//
// Two instances: dut_a (8 channels) carries the directed table, reset,
// packet and random tests; dut_b (6 channels, 2-bit drop counter) carries
// the out-of-range select and saturation tests. Inputs change on the
// falling edge and outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_stream_demux_1xn;

  localparam int A_NCH = 8;
  localparam int B_NCH = 6;
  localparam int SB_W  = 11;  // {sel[2:0], data[7:0]}

`ifdef DEMUX_PKT_LOCK_EN
  localparam bit PKT_MODE = 1'b1;
`else
  localparam bit PKT_MODE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT A ----------------
  logic       a_in_valid, a_in_ready, a_in_last;
  logic [7:0] a_in_data;
  logic [2:0] a_in_sel;
  logic [7:0] a_out_valid, a_out_ready, a_out_data;
  logic [15:0] a_drop_cnt;
  logic [1:0] a_dbg;

  stream_demux_1xn #(.N_CH(8), .SEL_W(3), .DATA_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .drop_cnt(a_drop_cnt), .dbg_state(a_dbg)
  );

  // ---------------- DUT B ----------------
  logic       b_in_valid, b_in_ready, b_in_last;
  logic [7:0] b_in_data;
  logic [2:0] b_in_sel;
  logic [5:0] b_out_valid, b_out_ready;
  logic [7:0] b_out_data;
  logic [1:0] b_drop_cnt;
  logic [1:0] b_dbg;

  stream_demux_1xn #(.N_CH(6), .SEL_W(3), .DATA_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt), .dbg_state(b_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic v, input logic [2:0] sel, input logic [7:0] d,
                         input logic last, input logic [7:0] rdy);
    a_in_valid  = v;
    a_in_sel    = sel;
    a_in_data   = d;
    a_in_last   = last;
    a_out_ready = rdy;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] sel, input logic [7:0] d,
                         input logic [5:0] rdy);
    b_in_valid  = v;
    b_in_sel    = sel;
    b_in_data   = d;
    b_in_last   = 1'b1;
    b_out_ready = rdy;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] rdy;
    logic [7:0] e_ov;
    logic [7:0] e_od;
    logic       e_ir;
  } vec_t;

  vec_t vecs[18];

  // ---------------- reference model (dut_a) ----------------
  // At most one beat is in flight; the queue holds it as {sel, data}.
  logic [SB_W-1:0] exp_q[$];
  logic [7:0]      m_last_data;
  int              m_drops;
  bit              m_busy;
  int              m_lock;

  task automatic model_reset();
    exp_q.delete();
    m_last_data = 8'h00;
    m_drops     = 0;
    m_busy      = 1'b0;
    m_lock      = 0;
  endtask

  function automatic logic [7:0] model_ov();
    logic [SB_W-1:0] b;
    if (exp_q.size() == 0) return 8'h00;
    b = exp_q[0];
    return 8'h01 << b[10:8];
  endfunction

  function automatic logic model_ir(input logic [7:0] rdy);
    logic [SB_W-1:0] b;
    if (exp_q.size() == 0) return 1'b1;
    b = exp_q[0];
    return rdy[b[10:8]];
  endfunction

  // Applies one clock edge to the model given the inputs of this cycle.
  task automatic model_step(input logic v, input logic [2:0] sel, input logic [7:0] d,
                            input logic last, input logic [7:0] rdy);
    logic acc;
    int   route;
    acc = v && model_ir(rdy);
    if (exp_q.size() != 0 && model_ir(rdy)) void'(exp_q.pop_front());
    if (acc) begin
      route = int'(sel);
      if (PKT_MODE) begin
        if (m_busy) begin
          route = m_lock;
          if (last) m_busy = 1'b0;
        end else begin
          m_lock = int'(sel);
          m_busy = !last;
        end
      end
      if (route < A_NCH) begin
        exp_q.push_back({3'(route), d});
        m_last_data = d;
      end else if (m_drops < 65535) begin
        m_drops++;
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] ov, od;
    logic       ir;
    logic       rv, rl;
    logic [2:0] rs;
    logic [7:0] rd, rr;

    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 3'(i), 8'hA0 + 8'(i), 8'hFF,
                  (i == 0) ? 8'h00 : (8'h01 << (i - 1)),
                  (i == 0) ? 8'h00 : (8'hA0 + 8'(i - 1)), 1'b1};
    end
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h80, 8'hA7, 1'b1};
    vecs[9]  = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'hA7, 1'b1};
    vecs[10] = '{1'b1, 3'd3, 8'h55, 8'hFF, 8'h00, 8'hA7, 1'b1};
    for (int i = 11; i < 15; i++) begin
      vecs[i] = '{1'b1, 3'd0, 8'h11, 8'hF7, 8'h08, 8'h55, 1'b0};
    end
    vecs[15] = '{1'b1, 3'd0, 8'h11, 8'hFF, 8'h08, 8'h55, 1'b1};
    vecs[16] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h01, 8'h11, 1'b1};
    vecs[17] = '{1'b0, 3'd0, 8'h00, 8'hFF, 8'h00, 8'h11, 1'b1};

    // --- reset: 2 clocks with a producer already offering a beat ---
    rst = 1'b1;
    drive_a(1'b1, 3'd1, 8'h99, 1'b1, 8'hFF);
    drive_b(1'b1, 3'd1, 8'h99, 6'h3F);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_out_valid", a_out_valid, 8'h00);
    chk("rst_a_out_data", a_out_data, 8'h00);
    chk("rst_a_drop_cnt", a_drop_cnt, 16'h0);
    chk("rst_a_in_ready", a_in_ready, 1'b0);
    chk("rst_a_dbg", a_dbg, 2'b00);
    chk("rst_b_in_ready", b_in_ready, 1'b0);
    chk("rst_b_drop_cnt", b_drop_cnt, 2'd0);
    rst = 1'b0;
    drive_a(1'b0, 3'd0, 8'h00, 1'b1, 8'hFF);
    drive_b(1'b0, 3'd0, 8'h00, 6'h3F);
    #1;
    chk("rel_a_in_ready", a_in_ready, 1'b1);

    // --- sweep + back-pressure hold, table driven ---
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive_a(vecs[i].v, vecs[i].sel, vecs[i].data, 1'b1, vecs[i].rdy);
      #1;
      chk($sformatf("vec%0d_out_valid", i), a_out_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d_out_data", i), a_out_data, vecs[i].e_od);
      chk($sformatf("vec%0d_in_ready", i), a_in_ready, vecs[i].e_ir);
    end

    // --- reset while holding a beat for channel 2 ---
    @(negedge clk);
    drive_a(1'b1, 3'd2, 8'h77, 1'b1, 8'h00);
    @(negedge clk);
    drive_a(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
    #1;
    chk("midrst_full_ov", a_out_valid, 8'h04);
    chk("midrst_full_dbg", a_dbg, 2'b01);
    rst = 1'b1;
    a_out_ready = 8'hFF;
    #1;
    chk("midrst_in_ready", a_in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("midrst_ov_cleared", a_out_valid, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("postrst%0d_ov", i), a_out_valid, 8'h00);
      chk($sformatf("postrst%0d_ir", i), a_in_ready, 1'b1);
    end
    chk("postrst_drop_cnt", a_drop_cnt, 16'h0);

    // --- dut_b: out-of-range selects, saturation, drop while draining ---
    @(negedge clk);
    drive_b(1'b1, 3'd6, 8'h66, 6'h3F);
    #1;
    chk("b_drop6_ready", b_in_ready, 1'b1);
    @(negedge clk);
    drive_b(1'b1, 3'd7, 8'h67, 6'h3F);
    #1;
    chk("b_drop7_ready", b_in_ready, 1'b1);
    chk("b_drop6_ov", b_out_valid, 6'h00);
    @(negedge clk);
    drive_b(1'b0, 3'd0, 8'h00, 6'h3F);
    #1;
    chk("b_drop7_ov", b_out_valid, 6'h00);
    chk("b_drop_cnt2", b_drop_cnt, 2'd2);
    @(negedge clk);
    drive_b(1'b1, 3'd6, 8'h01, 6'h3F);
    @(negedge clk);
    drive_b(1'b1, 3'd7, 8'h02, 6'h3F);
    #1;
    chk("b_drop_cnt3", b_drop_cnt, 2'd3);
    @(negedge clk);
    drive_b(1'b1, 3'd6, 8'h03, 6'h3F);
    @(negedge clk);
    drive_b(1'b0, 3'd0, 8'h00, 6'h3F);
    #1;
    chk("b_drop_cnt_sat", b_drop_cnt, 2'd3);
    chk("b_drop_out_data", b_out_data, 8'h00);
    @(negedge clk);
    drive_b(1'b1, 3'd5, 8'h5A, 6'h3F);
    @(negedge clk);
    drive_b(1'b1, 3'd6, 8'h6B, 6'h3F);
    #1;
    chk("b_ch5_ov", b_out_valid, 6'h20);
    chk("b_ch5_data", b_out_data, 8'h5A);
    chk("b_drain_drop_ready", b_in_ready, 1'b1);
    @(negedge clk);
    drive_b(1'b0, 3'd0, 8'h00, 6'h3F);
    #1;
    chk("b_drain_drop_empty", b_out_valid, 6'h00);
    chk("b_drain_drop_data", b_out_data, 8'h5A);
    chk("b_drain_drop_cnt", b_drop_cnt, 2'd3);

`ifdef DEMUX_PKT_LOCK_EN
    // --- packet lock: 3-beat packet on channel 5, then a fresh select ---
    @(negedge clk);
    drive_a(1'b1, 3'd5, 8'hC0, 1'b0, 8'hFF);
    @(negedge clk);
    drive_a(1'b1, 3'd1, 8'hC1, 1'b0, 8'hFF);
    #1;
    chk("pkt_b0_ov", a_out_valid, 8'h20);
    chk("pkt_b0_od", a_out_data, 8'hC0);
    chk("pkt_busy_dbg", a_dbg, 2'b11);
    @(negedge clk);
    drive_a(1'b1, 3'd2, 8'hC2, 1'b1, 8'hFF);
    #1;
    chk("pkt_b1_ov", a_out_valid, 8'h20);
    chk("pkt_b1_od", a_out_data, 8'hC1);
    @(negedge clk);
    drive_a(1'b1, 3'd1, 8'hC3, 1'b1, 8'hFF);
    #1;
    chk("pkt_b2_ov", a_out_valid, 8'h20);
    chk("pkt_b2_od", a_out_data, 8'hC2);
    @(negedge clk);
    drive_a(1'b0, 3'd0, 8'h00, 1'b1, 8'hFF);
    #1;
    chk("pkt_next_ov", a_out_valid, 8'h02);
    chk("pkt_next_od", a_out_data, 8'hC3);
    chk("pkt_idle_dbg", a_dbg, 2'b01);
`endif

    // --- randomized traffic against the reference model ---
    @(negedge clk);
    rst = 1'b1;
    drive_a(1'b0, 3'd0, 8'h00, 1'b1, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 3) != 0);
      rs = 3'($urandom_range(0, 7));
      rd = 8'($urandom_range(0, 255));
      rl = ($urandom_range(0, 2) == 0);
      rr = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) rr = 8'hFF;
      drive_a(rv, rs, rd, rl, rr);
      #1;
      ov = model_ov();
      od = m_last_data;
      ir = model_ir(rr);
      chk("rnd_out_valid", a_out_valid, ov);
      chk("rnd_out_data", a_out_data, od);
      chk("rnd_in_ready", a_in_ready, ir);
      model_step(rv, rs, rd, rl, rr);
    end
    @(negedge clk);
    drive_a(1'b0, 3'd0, 8'h00, 1'b1, 8'hFF);
    #1;
    chk("rnd_final_ov", a_out_valid, model_ov());
    chk("rnd_drop_cnt", a_drop_cnt, 16'(m_drops));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "time limit");
  end

endmodule
